// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between a controller (master) and the responder (slave).
// Carries CKE, CS/RAS/CAS/WE, bank, address, DQM, write data in, read data out + OE.
interface sdram_responder_if;
    logic        dram_cke;
    logic        dram_cs_n;
    logic        dram_ras_n;
    logic        dram_cas_n;
    logic        dram_we_n;
    logic        dram_ba_0;
    logic        dram_ba_1;
    logic [11:0] dram_addr;
    logic        dram_ldqm;
    logic        dram_udqm;
    logic [15:0] dram_dq_in;
    logic [15:0] dram_dq_out;
    logic        dram_dq_oe;

    modport master (
        output dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
        output dram_ba_0, dram_ba_1, dram_addr, dram_ldqm, dram_udqm,
        output dram_dq_in,
        input  dram_dq_out, dram_dq_oe
    );

    modport slave (
        input  dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
        input  dram_ba_0, dram_ba_1, dram_addr, dram_ldqm, dram_udqm,
        input  dram_dq_in,
        output dram_dq_out, dram_dq_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// Device-side SDRAM model: init order, tRP/tRFC/tMRD spacing, open rows, CL read pipe.
// Ports: dram_clk, reset (sync, high), bus (slave), mode_reg, init_done, err_* flags.
// Optional: SDRAM_RESPONDER_REFRESH_CHECK_EN enables the refresh-interval check (err_refresh).
module sdram_responder #(
    parameter int INIT_WAIT_CYCLES   = 33200,
    parameter int T_RP               = 3,
    parameter int T_RFC              = 11,
    parameter int T_MRD              = 4,
    parameter int MEM_ADDR_BITS      = 10,
    parameter int REFRESH_MAX_CYCLES = 1296
) (
    input  logic                dram_clk,
    input  logic                reset,
    sdram_responder_if.slave    bus,
    output logic [11:0]         mode_reg,
    output logic                init_done,
    output logic                err_init,
    output logic                err_timing,
    output logic                err_bank,
    output logic                err_mode,
    output logic                err_refresh
);

    localparam logic [2:0] S_POWERUP  = 3'd0;
    localparam logic [2:0] S_WAIT_PRE = 3'd1;
    localparam logic [2:0] S_WAIT_REF = 3'd2;
    localparam logic [2:0] S_MRD      = 3'd3;
    localparam logic [2:0] S_READY    = 3'd4;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

    localparam int IW   = $clog2(INIT_WAIT_CYCLES + 1);
    localparam int TMAX = (T_RFC > T_RP) ? ((T_RFC > T_MRD) ? T_RFC : T_MRD)
                                         : ((T_RP > T_MRD) ? T_RP : T_MRD);
    localparam int TW   = $clog2(TMAX + 1);

    logic [2:0]        cmd;
    logic              active;
    logic [1:0]        ba;
    logic              mode_ok;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic [15:0]       rdata;

    logic [2:0]        state_q, state_d;
    logic [IW-1:0]     icnt_q, icnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [1:0]        refs_q, refs_d;
    logic [11:0]       mode_q, mode_d;
    logic              cl3_q, cl3_d;
    logic [3:0]        open_q, open_d;
    logic [3:0][11:0]  row_q, row_d;
    logic              init_q, init_d;
    logic              einit_q, einit_d;
    logic              etim_q, etim_d;
    logic              ebank_q, ebank_d;
    logic              emode_q, emode_d;
    logic              lmr_go, wr_go, rd_go;

    // Read pipe: s2 only used for CL=3; DQM is applied on entry to s1.
    logic              p2v_q, p2v_d, p1v_q, p1v_d, oe_q, oe_d;
    logic [15:0]       p2d_q, p2d_d, p1d_q, p1d_d, dout_q, dout_d;

    logic [15:0]       mem_q [2**MEM_ADDR_BITS];

    assign cmd     = bus.dram_cs_n ? C_NOP
                   : {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n};
    assign active  = bus.dram_cke && (cmd != C_NOP);
    assign ba      = {bus.dram_ba_1, bus.dram_ba_0};
    assign mode_ok = (bus.dram_addr[6:5] == 2'b01) && (bus.dram_addr[2:0] == 3'b000);
    // Upper bank/row/column bits alias onto the small backing RAM.
    assign idx     = MEM_ADDR_BITS'({ba, row_q[ba], bus.dram_addr[7:0]});
    assign rdata   = mem_q[idx];

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        tcnt_d  = tcnt_q;
        refs_d  = refs_q;
        mode_d  = mode_q;
        cl3_d   = cl3_q;
        open_d  = open_q;
        row_d   = row_q;
        init_d  = init_q;
        einit_d = einit_q;
        etim_d  = etim_q;
        ebank_d = ebank_q;
        emode_d = emode_q;
        lmr_go  = 1'b0;
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        if (bus.dram_cke) begin
            if (tcnt_q != '0) tcnt_d = tcnt_q - 1'b1;
            if (active && tcnt_q != '0) etim_d = 1'b1;
            case (state_q)
                S_POWERUP: begin
                    if (active) begin
                        einit_d = 1'b1;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                        if (icnt_q == IW'(INIT_WAIT_CYCLES - 1)) state_d = S_WAIT_PRE;
                    end
                end
                S_WAIT_PRE: begin
                    if (active) begin
                        if (cmd == C_PRE && bus.dram_addr[10]) begin
                            state_d = S_WAIT_REF;
                            tcnt_d  = TW'(T_RP - 1);
                            refs_d  = 2'd0;
                        end else begin
                            einit_d = 1'b1;
                        end
                    end
                end
                S_WAIT_REF: begin
                    if (active) begin
                        if (cmd == C_REF) begin
                            tcnt_d = TW'(T_RFC - 1);
                            if (!refs_q[1]) refs_d = refs_q + 1'b1;
                        end else if (cmd == C_LMR && refs_q[1]) begin
                            lmr_go  = 1'b1;
                            state_d = S_MRD;
                        end else begin
                            einit_d = 1'b1;
                        end
                    end
                end
                S_MRD, S_READY: begin
                    // Leave MRD one edge early so init_done is up T_MRD clocks after LOAD_MODE.
                    if (state_q == S_MRD && tcnt_q <= TW'(1)) begin
                        state_d = S_READY;
                        init_d  = 1'b1;
                    end
                    if (active) begin
                        case (cmd)
                            C_LMR: lmr_go = 1'b1;
                            C_REF: begin
                                tcnt_d = TW'(T_RFC - 1);
                                if (|open_q) ebank_d = 1'b1;
                            end
                            C_PRE: begin
                                tcnt_d = TW'(T_RP - 1);
                                if (bus.dram_addr[10]) open_d = 4'b0000;
                                else                   open_d[ba] = 1'b0;
                            end
                            C_ACT: begin
                                if (open_q[ba]) begin
                                    ebank_d = 1'b1;
                                end else begin
                                    open_d[ba] = 1'b1;
                                    row_d[ba]  = bus.dram_addr;
                                end
                            end
                            C_WR, C_RD: begin
                                if (state_q != S_READY) einit_d = 1'b1;
                                else if (!open_q[ba])   ebank_d = 1'b1;
                                else if (cmd == C_WR)   wr_go   = 1'b1;
                                else                    rd_go   = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = S_POWERUP;
            endcase
            if (lmr_go) begin
                mode_d = bus.dram_addr;
                tcnt_d = TW'(T_MRD - 1);
                if (mode_ok) begin
                    cl3_d = bus.dram_addr[4];
                end else begin
                    emode_d = 1'b1;
                    cl3_d   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        p2v_d  = p2v_q;
        p2d_d  = p2d_q;
        p1v_d  = p1v_q;
        p1d_d  = p1d_q;
        oe_d   = oe_q;
        dout_d = dout_q;
        if (bus.dram_cke) begin
            p2v_d = rd_go && cl3_q;
            p2d_d = rdata;
            if (cl3_q) begin
                p1v_d = p2v_q;
                p1d_d = p2d_q;
            end else begin
                p1v_d = rd_go;
                p1d_d = rdata;
            end
            p1d_d[7:0]  = bus.dram_ldqm ? 8'h00 : p1d_d[7:0];
            p1d_d[15:8] = bus.dram_udqm ? 8'h00 : p1d_d[15:8];
            oe_d   = p1v_q;
            dout_d = p1v_q ? p1d_q : 16'h0000;
        end
    end

    always_ff @(posedge dram_clk) begin
        if (reset) begin
            state_q <= S_POWERUP;
            icnt_q  <= '0;
            tcnt_q  <= '0;
            refs_q  <= 2'd0;
            mode_q  <= 12'h000;
            cl3_q   <= 1'b1;
            open_q  <= 4'b0000;
            row_q   <= '0;
            init_q  <= 1'b0;
            einit_q <= 1'b0;
            etim_q  <= 1'b0;
            ebank_q <= 1'b0;
            emode_q <= 1'b0;
            p2v_q   <= 1'b0;
            p2d_q   <= 16'h0000;
            p1v_q   <= 1'b0;
            p1d_q   <= 16'h0000;
            oe_q    <= 1'b0;
            dout_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            tcnt_q  <= tcnt_d;
            refs_q  <= refs_d;
            mode_q  <= mode_d;
            cl3_q   <= cl3_d;
            open_q  <= open_d;
            row_q   <= row_d;
            init_q  <= init_d;
            einit_q <= einit_d;
            etim_q  <= etim_d;
            ebank_q <= ebank_d;
            emode_q <= emode_d;
            p2v_q   <= p2v_d;
            p2d_q   <= p2d_d;
            p1v_q   <= p1v_d;
            p1d_q   <= p1d_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
        end
    end

    // Backing RAM keeps its contents across reset.
    always_ff @(posedge dram_clk) begin
        if (wr_go && !reset) begin
            if (!bus.dram_ldqm) mem_q[idx][7:0]  <= bus.dram_dq_in[7:0];
            if (!bus.dram_udqm) mem_q[idx][15:8] <= bus.dram_dq_in[15:8];
        end
    end

`ifdef SDRAM_RESPONDER_REFRESH_CHECK_EN
    localparam int RW = $clog2(REFRESH_MAX_CYCLES + 2);
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          eref_q, eref_d;

    always_comb begin
        rcnt_d = rcnt_q;
        eref_d = eref_q;
        if (bus.dram_cke) begin
            if (active && cmd == C_REF) begin
                rcnt_d = '0;
            end else if (init_q && rcnt_q <= RW'(REFRESH_MAX_CYCLES)) begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == RW'(REFRESH_MAX_CYCLES)) eref_d = 1'b1;
            end
        end
    end

    always_ff @(posedge dram_clk) begin
        if (reset) begin
            rcnt_q <= '0;
            eref_q <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            eref_q <= eref_d;
        end
    end

    assign err_refresh = eref_q;
`else
    // No refresh check: flag is constant 0 (REFRESH_MAX_CYCLES kept referenced).
    assign err_refresh = 1'b0 && (REFRESH_MAX_CYCLES != 0);
`endif

    assign bus.dram_dq_out = dout_q;
    assign bus.dram_dq_oe  = oe_q;
    assign mode_reg        = mode_q;
    assign init_done       = init_q;
    assign err_init        = einit_q;
    assign err_timing      = etim_q;
    assign err_bank        = ebank_q;
    assign err_mode        = emode_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: init sequences, table-driven read/write, error flags.
// Read data is checked by a scoreboard queue of {expected cycle, expected data}.
module tb_sdram_responder;

    localparam int CL = 3;
    localparam logic [2:0] LMR = 3'b000;
    localparam logic [2:0] REF = 3'b001;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] NOP = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mode_reg;
    logic        init_done, err_init, err_timing, err_bank, err_mode, err_refresh;

    sdram_responder_if bus();

    sdram_responder #(
        .INIT_WAIT_CYCLES   (16),
        .T_RP               (3),
        .T_RFC              (11),
        .T_MRD              (4),
        .MEM_ADDR_BITS      (10),
        .REFRESH_MAX_CYCLES (100)
    ) dut (
        .dram_clk    (clk),
        .reset       (rst),
        .bus         (bus),
        .mode_reg    (mode_reg),
        .init_done   (init_done),
        .err_init    (err_init),
        .err_timing  (err_timing),
        .err_bank    (err_bank),
        .err_mode    (err_mode),
        .err_refresh (err_refresh)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    typedef struct {
        logic [2:0]  c;
        logic [1:0]  ba;
        logic [11:0] a;
        logic        lq;
        logic        uq;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;
    localparam int NV = 18;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [1:0] ba, input logic [11:0] a,
                         input logic lq, input logic uq, input logic [15:0] d);
        @(posedge clk);
        #1;
        bus.dram_cs_n  = (c == NOP);
        bus.dram_ras_n = c[2];
        bus.dram_cas_n = c[1];
        bus.dram_we_n  = c[0];
        bus.dram_ba_1  = ba[1];
        bus.dram_ba_0  = ba[0];
        bus.dram_addr  = a;
        bus.dram_ldqm  = lq;
        bus.dram_udqm  = uq;
        bus.dram_dq_in = d;
    endtask

    task automatic nop(input int n);
        repeat (n) drive(NOP, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000);
    endtask

    // Reset for two edges; the bus holds NOP so the first released edge counts as a NOP.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.dram_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Read data must arrive exactly when its scoreboard entry says.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL rd_missing: got no data by cyc %0d want %h at cyc %0d", cyc, e.data, e.cyc);
        end
        if (bus.dram_dq_oe === 1'b1) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL rd_spurious: got oe=1 data %h at cyc %0d want oe=0", bus.dram_dq_out, cyc);
            end else begin
                e = sbq.pop_front();
                if (e.cyc != cyc || e.data !== bus.dram_dq_out) begin
                    n_bad++;
                    $display("FAIL rd_data: got %h at cyc %0d want %h at cyc %0d",
                             bus.dram_dq_out, cyc, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL timeout: got no end of test want end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        tbl[0]  = '{ACT, 2'd1, 12'h2A5, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{WR,  2'd1, 12'h010, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        tbl[2]  = '{RD,  2'd1, 12'h010, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
        tbl[3]  = '{NOP, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[4]  = '{NOP, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[5]  = '{WR,  2'd1, 12'h010, 1'b0, 1'b1, 16'h1234, 16'h0000};
        tbl[6]  = '{RD,  2'd1, 12'h010, 1'b0, 1'b0, 16'h0000, 16'hBE34};
        tbl[7]  = '{NOP, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[8]  = '{RD,  2'd1, 12'h010, 1'b0, 1'b0, 16'h0000, 16'hBE00};
        tbl[9]  = '{NOP, 2'd0, 12'h000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[10] = '{NOP, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[11] = '{WR,  2'd1, 12'h020, 1'b0, 1'b0, 16'hA5A5, 16'h0000};
        tbl[12] = '{RD,  2'd1, 12'h010, 1'b0, 1'b0, 16'h0000, 16'hBE34};
        tbl[13] = '{RD,  2'd1, 12'h020, 1'b0, 1'b0, 16'h0000, 16'hA5A5};
        tbl[14] = '{ACT, 2'd0, 12'h001, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[15] = '{RD,  2'd0, 12'h010, 1'b0, 1'b0, 16'h0000, 16'hBE34};
        tbl[16] = '{NOP, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[17] = '{NOP, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 16'h0000};

        rst = 1'b1;
        bus.dram_cke   = 1'b1;
        bus.dram_cs_n  = 1'b1;
        bus.dram_ras_n = 1'b1;
        bus.dram_cas_n = 1'b1;
        bus.dram_we_n  = 1'b1;
        bus.dram_ba_0  = 1'b0;
        bus.dram_ba_1  = 1'b0;
        bus.dram_addr  = 12'h000;
        bus.dram_ldqm  = 1'b0;
        bus.dram_udqm  = 1'b0;
        bus.dram_dq_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", init_done, 0);
        check("rst_mode_reg", mode_reg, 0);
        check("rst_errs", {err_init, err_timing, err_bank, err_mode, err_refresh}, 0);
        check("rst_oe", bus.dram_dq_oe, 0);

        // Early PRECHARGE on the 5th wait cycle.
        do_reset();
        nop(3);
        drive(PRE, 2'd0, 12'h400, 1'b0, 1'b0, 16'h0000);
        nop(3);
        check("early_pre_err_init", err_init, 1);
        check("early_pre_init_done", init_done, 0);

        // Full init with exactly 16 wait NOPs.
        do_reset();
        nop(15);
        drive(PRE, 2'd0, 12'h400, 1'b0, 1'b0, 16'h0000);
        nop(3);
        drive(REF, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000);
        nop(10);
        drive(REF, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000);
        nop(10);
        drive(LMR, 2'd0, 12'h030, 1'b0, 1'b0, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            nop(1);
            check($sformatf("init_done_k%0d", k), init_done, (k == 4));
        end
        check("init_mode_reg", mode_reg, 12'h030);
        check("init_errs", {err_init, err_timing, err_bank, err_mode}, 0);

        // Refresh interval: 95 then 105 idle clocks after init_done.
        nop(95);
        check("refresh_95", err_refresh, 0);
        nop(10);
`ifdef SDRAM_RESPONDER_REFRESH_CHECK_EN
        check("refresh_105", err_refresh, 1);
`else
        check("refresh_105", err_refresh, 0);
`endif

        // Table of writes/reads; reads push expected data at issue edge + CL - 1,
        // seen at the negedge where cyc = drive cyc + CL.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].c, tbl[i].ba, tbl[i].a, tbl[i].lq, tbl[i].uq, tbl[i].d);
            if (tbl[i].c == RD) sbq.push_back('{cyc + CL, tbl[i].exp});
        end
        nop(6);
        check("table_drained", sbq.size(), 0);
        check("table_errs", {err_init, err_timing, err_bank, err_mode}, 0);

        // REFRESH then ACTIVE 5 clocks later; then READ to closed bank 2.
        drive(PRE, 2'd0, 12'h400, 1'b0, 1'b0, 16'h0000);
        nop(3);
        drive(REF, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0000);
        nop(4);
        drive(ACT, 2'd0, 12'h005, 1'b0, 1'b0, 16'h0000);
        nop(1);
        check("trfc_err_timing", err_timing, 1);
        check("trfc_err_bank", err_bank, 0);
        nop(10);
        drive(RD, 2'd2, 12'h010, 1'b0, 1'b0, 16'h0000);
        nop(1);
        check("closed_rd_err_bank", err_bank, 1);
        nop(5);

        // Illegal CAS latency.
        drive(LMR, 2'd0, 12'h010, 1'b0, 1'b0, 16'h0000);
        nop(1);
        check("bad_cl_err_mode", err_mode, 1);
        check("bad_cl_mode_reg", mode_reg, 12'h010);
        nop(4);

        // READ then reset on the next edge: no data may appear.
        drive(RD, 2'd0, 12'h010, 1'b0, 1'b0, 16'h0000);
        do_reset();
        check("mid_rst_oe", bus.dram_dq_oe, 0);
        check("mid_rst_state", {init_done, mode_reg}, 0);
        check("mid_rst_errs", {err_init, err_timing, err_bank, err_mode, err_refresh}, 0);
        nop(5);
        check("final_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
